// File: rtl/ins_cache_pkg.sv
// Shared geometry, FSM state encoding and block-address layout for the
// instruction cache controller.
package ins_cache_pkg;
  localparam int INDEX_BITS    = 3;
  localparam int TAG_BITS      = 3;
  localparam int OFFSET_BITS   = 2;
  localparam int BLOCK_BITS    = 128;
  localparam int WORD_BITS     = 32;
  localparam int LINES         = 1 << INDEX_BITS;
  localparam int WORDS         = BLOCK_BITS / WORD_BITS;
  localparam int ADDR_BITS     = TAG_BITS + INDEX_BITS + OFFSET_BITS + 2;
  localparam int BLK_ADDR_BITS = TAG_BITS + INDEX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} ins_cache_state_t;

  typedef struct packed {
    logic [TAG_BITS-1:0]   tag;
    logic [INDEX_BITS-1:0] index;
  } blk_addr_t;
endpackage

// File: rtl/ins_cache_array.sv
// Line storage: valid/tag/data arrays, one synchronous write port and a
// combinational read of the indexed line with word select.
module ins_cache_array
  import ins_cache_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_BITS-1:0]  rd_index,
  input  logic [OFFSET_BITS-1:0] rd_offset,
  output logic                   rd_valid,
  output logic [TAG_BITS-1:0]    rd_tag,
  output logic [WORD_BITS-1:0]   rd_word,
  input  logic                   wr_en,
  input  logic [INDEX_BITS-1:0]  wr_index,
  input  logic [TAG_BITS-1:0]    wr_tag,
  input  logic [BLOCK_BITS-1:0]  wr_data
);
  logic [LINES-1:0]                            valid;
  logic [LINES-1:0][TAG_BITS-1:0]              tags;
  logic [LINES-1:0][WORDS-1:0][WORD_BITS-1:0]  data;

  // Only valid bits are reset; tag/data are qualified by valid.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     valid           <= '0;
    else if (wr_en) valid[wr_index] <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tags[wr_index] <= wr_tag;
      data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_word  = data[rd_index][rd_offset];
endmodule

// File: rtl/ins_cache_controller.sv
// Direct-mapped instruction cache: zero-wait hits, blocking refill of a
// 16-byte line from instruction memory on a miss.
module ins_cache_controller
  import ins_cache_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     read,
  input  logic [ADDR_BITS-1:0]     address,
  output logic [WORD_BITS-1:0]     instruction,
  output logic                     busywait,
  output logic                     mem_read,
  output logic [BLK_ADDR_BITS-1:0] mem_address,
  input  logic [BLOCK_BITS-1:0]    mem_readdata,
  input  logic                     mem_busywait
);
  ins_cache_state_t state, state_next;
  blk_addr_t        miss_addr;
  blk_addr_t        cur_blk;
  logic [BLOCK_BITS-1:0] fill_data;
  logic [OFFSET_BITS-1:0] offset;
  logic             line_valid, hit, wr_en, busy_raw, unused_byte_sel;
  logic [TAG_BITS-1:0] line_tag;

  assign cur_blk         = blk_addr_t'(address[ADDR_BITS-1:OFFSET_BITS+2]);
  assign offset          = address[OFFSET_BITS+1:2];
  assign unused_byte_sel = ^address[1:0];

  ins_cache_array u_array (
    .clock     (clock),
    .reset     (reset),
    .rd_index  (cur_blk.index),
    .rd_offset (offset),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_word   (instruction),
    .wr_en     (wr_en),
    .wr_index  (miss_addr.index),
    .wr_tag    (miss_addr.tag),
    .wr_data   (fill_data)
  );

  assign hit = read & line_valid & (line_tag == cur_blk.tag);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // A miss is only launched once any pre-reset access has drained.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      miss_addr <= '0;
    else if (state == IDLE && read && !hit && !mem_busywait)
      miss_addr <= cur_blk;
  end

  always_ff @(posedge clock) begin
    if (state == MEM_READ && !mem_busywait) fill_data <= mem_readdata;
  end

  always_comb begin
    state_next = state;
    busy_raw   = 1'b0;
    mem_read   = 1'b0;
    wr_en      = 1'b0;
    case (state)
      IDLE: begin
        busy_raw = read & ~hit;
        if (read && !hit && !mem_busywait) state_next = MEM_READ;
      end
      MEM_READ: begin
        busy_raw = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) state_next = UPDATE;
      end
      UPDATE: begin
        busy_raw   = 1'b1;
        wr_en      = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall drops the moment reset asserts, not at the next edge.
  assign busywait    = busy_raw & reset;
  assign mem_address = miss_addr;
endmodule

// File: tb/tb_ins_cache_controller.sv
// Scoreboard bench: stimulus queues expected words and refill addresses,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_ins_cache_controller;
  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         read  = 1'b0;
  logic [9:0]   address = '0;
  logic [31:0]  instruction;
  logic         busywait, mem_read, mem_busywait;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0]  exp_instr_q[$];
  logic [5:0]   exp_maddr_q[$];
  logic [5:0]   cur_maddr = '0;
  logic         mr_prev = 1'b0;

  logic [127:0] mem_blocks [64];
  logic         m_active = 1'b0;
  int           m_cnt = 0;
  logic [5:0]   m_blk = '0;

  ins_cache_controller dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
  );

  always #5 clock = ~clock;

  // Memory model: busy rises with mem_read, access completes LAT cycles
  // later and keeps running across a cache reset.
  always @(posedge clock) begin
    if (m_active) begin
      if (m_cnt == 0) m_active <= 1'b0;
      else            m_cnt    <= m_cnt - 1;
    end else if (mem_read) begin
      m_active <= 1'b1;
      m_cnt    <= LAT;
      m_blk    <= mem_address;
    end
  end
  assign mem_busywait = (mem_read && !m_active) || (m_active && m_cnt != 0);
  assign mem_readdata = m_active ? mem_blocks[m_blk] : '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  function automatic logic [31:0] exp_word(input logic [9:0] a);
    logic [127:0] b;
    b = mem_blocks[a[9:4]];
    return b[32*int'(a[3:2]) +: 32];
  endfunction

  always @(negedge clock) begin
    if (reset) begin
      if (read && !busywait) begin
        if (exp_instr_q.size() == 0) fail("instr_unexpected");
        else check("instruction", instruction, exp_instr_q.pop_front());
      end
      if (mem_read && !mr_prev) begin
        if (exp_maddr_q.size() == 0) fail("refill_unexpected");
        else cur_maddr = exp_maddr_q.pop_front();
      end
      if (mem_read) check("mem_address", {26'd0, mem_address}, {26'd0, cur_maddr});
    end
    mr_prev <= mem_read;
  end

  // Called at posedge+1; returns at posedge+1 after the completing cycle.
  task automatic fetch(input logic [9:0] a, input bit miss);
    int cyc;
    address = a;
    read    = 1'b1;
    exp_instr_q.push_back(exp_word(a));
    if (miss) exp_maddr_q.push_back(a[9:4]);
    @(negedge clock);
    check($sformatf("busywait_c0_%h", a), {31'd0, busywait}, {31'd0, miss});
    if (!miss) check($sformatf("hit_mem_read_%h", a), {31'd0, mem_read}, 32'd0);
    cyc = 0;
    while (busywait && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (busywait) fail($sformatf("fetch_timeout_%h", a));
    @(posedge clock); #1;
  endtask

  task automatic wait_busy_low(input string name);
    int cyc;
    cyc = 0;
    while (busywait && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    if (busywait) fail(name);
    @(posedge clock); #1;
  endtask

  initial begin
    int cyc;
    for (int b = 0; b < 64; b++)
      for (int w = 0; w < 4; w++)
        mem_blocks[b][32*w +: 32] = {8'(b), 8'(w), 16'hC0DE};
    mem_blocks[0] = {32'h0A000704, 32'h0A000603, 32'h00070005, 32'h00060002};
    mem_blocks[1] = {32'h03000637, 32'h03000627, 32'h03000617, 32'h03000607};

    // Reset state
    @(negedge clock);
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", {26'd0, mem_address}, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    // Cold fetch and sequential hits
    fetch(10'h000, 1);
    fetch(10'h004, 0);
    fetch(10'h008, 0);
    fetch(10'h00C, 0);

    // Idle with uncached address
    read = 1'b0;
    address = 10'h3F0;
    @(negedge clock);
    check("idle_busywait", {31'd0, busywait}, 32'd0);
    check("idle_mem_read", {31'd0, mem_read}, 32'd0);
    @(posedge clock); #1;

    // Conflict miss on index 0
    fetch(10'h080, 1);
    fetch(10'h000, 1);
    fetch(10'h004, 0);

    // Address change during MEM_READ: refill still uses block 0x02
    address = 10'h020;
    read    = 1'b1;
    exp_maddr_q.push_back(6'h02);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!mem_read && cyc < 20);
    if (!mem_read) fail("unstable_no_refill");
    @(posedge clock); #1;
    address = 10'h040;
    exp_maddr_q.push_back(6'h04);
    exp_instr_q.push_back(exp_word(10'h040));
    wait_busy_low("unstable_timeout");
    fetch(10'h024, 0);
    fetch(10'h048, 0);

    // Reset during MEM_READ with a slow access still in flight
    address = 10'h050;
    read    = 1'b1;
    exp_maddr_q.push_back(6'h05);
    cyc = 0;
    do begin
      @(negedge clock);
      cyc++;
    end while (!mem_read && cyc < 20);
    if (!mem_read) fail("midrst_no_refill");
    @(posedge clock); #2;
    reset = 1'b0;
    #1;
    check("midrst_mem_read", {31'd0, mem_read}, 32'd0);
    check("midrst_busywait", {31'd0, busywait}, 32'd0);
    @(posedge clock); #1;
    reset   = 1'b1;
    address = 10'h010;
    @(negedge clock);
    check("drain_busywait", {31'd0, busywait}, 32'd1);
    check("drain_mem_read", {31'd0, mem_read}, 32'd0);
    exp_maddr_q.push_back(6'h01);
    exp_instr_q.push_back(exp_word(10'h010));
    wait_busy_low("drain_timeout");
    fetch(10'h01C, 0);
    fetch(10'h000, 1);

    read = 1'b0;
    @(posedge clock); #1;
    check("instr_q_empty", exp_instr_q.size(), 32'd0);
    check("maddr_q_empty", exp_maddr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
